// File: rtl/core_ex_alu_arb_if.sv
// Bundle of request, response and shared-ALU signals between the EX-stage
// requesters, the external ALU and the ALU arbiter.
interface core_ex_alu_arb_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  flush;

    logic                  p0_req_valid;
    logic                  p0_req_ready;
    logic [3:0]            p0_alu_op;
    logic [DATA_WIDTH-1:0] p0_op1;
    logic [DATA_WIDTH-1:0] p0_op2;
    logic                  p0_rsp_valid;
    logic                  p0_rsp_ready;
    logic [DATA_WIDTH-1:0] p0_rsp_data;

    logic                  p1_req_valid;
    logic                  p1_req_ready;
    logic [3:0]            p1_alu_op;
    logic [DATA_WIDTH-1:0] p1_op1;
    logic [DATA_WIDTH-1:0] p1_op2;
    logic                  p1_rsp_valid;
    logic                  p1_rsp_ready;
    logic [DATA_WIDTH-1:0] p1_rsp_data;

    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_op1;
    logic [DATA_WIDTH-1:0] alu_op2;
    logic [DATA_WIDTH-1:0] alu_res;

    logic                  busy;

    // Requesters plus the ALU itself: everything the arbiter does not drive.
    modport master (
        output flush,
        output p0_req_valid, p0_alu_op, p0_op1, p0_op2, p0_rsp_ready,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_data,
        output p1_req_valid, p1_alu_op, p1_op1, p1_op2, p1_rsp_ready,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_data,
        input  alu_op, alu_op1, alu_op2,
        output alu_res,
        input  busy
    );

    modport slave (
        input  flush,
        input  p0_req_valid, p0_alu_op, p0_op1, p0_op2, p0_rsp_ready,
        output p0_req_ready, p0_rsp_valid, p0_rsp_data,
        input  p1_req_valid, p1_alu_op, p1_op1, p1_op2, p1_rsp_ready,
        output p1_req_ready, p1_rsp_valid, p1_rsp_data,
        output alu_op, alu_op1, alu_op2,
        input  alu_res,
        output busy
    );
endinterface

// File: rtl/core_ex_alu_arb.sv
// Two-port arbiter for the shared EX-stage ALU: picks one request per cycle,
// buffers the result in a single entry and guarantees port-1 forward progress.
module core_ex_alu_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst_n,
    core_ex_alu_arb_if.slave bus
);
    localparam logic [0:0] ST_EMPTY   = 1'b0;
    localparam logic [0:0] ST_FULL    = 1'b1;
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [0:0]            state;
    logic                  buf_owner;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [2:0]            starve_cnt;

    logic buf_valid;
    logic p0_eff;
    logic gnt0;
    logic gnt1;
    logic drain;
    logic flush_kill;
    logic space;
    logic acc0;
    logic acc1;

    // A flush frees a p0-owned entry, which lets p1 land in the same cycle.
    always_comb begin
        buf_valid  = (state == ST_FULL);
        p0_eff     = bus.p0_req_valid & ~bus.flush;
        gnt1       = bus.p1_req_valid & (~p0_eff | (starve_cnt == STARVE_LIM));
        gnt0       = p0_eff & ~gnt1;
        drain      = buf_valid & (buf_owner ? bus.p1_rsp_ready : bus.p0_rsp_ready);
        flush_kill = buf_valid & ~buf_owner & bus.flush;
        space      = ~buf_valid | drain | flush_kill;
        acc0       = gnt0 & space;
        acc1       = gnt1 & space;
    end

    always_comb begin
        bus.alu_op  = 4'd0;
        bus.alu_op1 = '0;
        bus.alu_op2 = '0;
        if (gnt1) begin
            bus.alu_op  = bus.p1_alu_op;
            bus.alu_op1 = bus.p1_op1;
            bus.alu_op2 = bus.p1_op2;
        end else if (gnt0) begin
            bus.alu_op  = bus.p0_alu_op;
            bus.alu_op1 = bus.p0_op1;
            bus.alu_op2 = bus.p0_op2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            buf_owner <= 1'b0;
            buf_data  <= '0;
        end else if (acc0 | acc1) begin
            state     <= ST_FULL;
            buf_owner <= acc1;
            buf_data  <= bus.alu_res;
        end else if (drain | flush_kill) begin
            state     <= ST_EMPTY;
        end
    end

    // Any cycle p1 asks and is not taken counts, including back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 3'd0;
        end else if (!bus.p1_req_valid || acc1) begin
            starve_cnt <= 3'd0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

    assign bus.p0_req_ready = acc0;
    assign bus.p1_req_ready = acc1;
    assign bus.p0_rsp_valid = buf_valid & ~buf_owner;
    assign bus.p1_rsp_valid = buf_valid & buf_owner;
    assign bus.p0_rsp_data  = (buf_valid & ~buf_owner) ? buf_data : '0;
    assign bus.p1_rsp_data  = (buf_valid & buf_owner) ? buf_data : '0;
    assign bus.busy         = buf_valid;
endmodule

// File: tb/tb_core_ex_alu_arb.sv
// Directed bench for core_ex_alu_arb with a per-cycle reference model and
// hand-computed spot checks.
module tb_core_ex_alu_arb;
    localparam int STARVE_MAX = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    core_ex_alu_arb_if #(.DATA_WIDTH(32)) bus ();

    core_ex_alu_arb #(.DATA_WIDTH(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a & ~b;
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_res = alu_ref(bus.alu_op, bus.alu_op1, bus.alu_op2);

    // Reference model: who owns the result slot and how long p1 has waited.
    bit          m_valid   = 1'b0;
    bit          m_owner   = 1'b0;
    logic [31:0] m_data    = 32'd0;
    int          m_refused = 0;

    function automatic int grant_now();
        bit p0_wants;
        p0_wants = bus.p0_req_valid && !bus.flush;
        if (bus.p1_req_valid && (!p0_wants || m_refused >= STARVE_MAX)) return 1;
        if (p0_wants) return 0;
        return -1;
    endfunction

    function automatic bit room_now();
        if (!m_valid) return 1'b1;
        if (m_owner ? bus.p1_rsp_ready : bus.p0_rsp_ready) return 1'b1;
        return bus.flush && !m_owner;
    endfunction

    function automatic logic [31:0] winner_result();
        if (grant_now() == 1) return alu_ref(bus.p1_alu_op, bus.p1_op1, bus.p1_op2);
        return alu_ref(bus.p0_alu_op, bus.p0_op1, bus.p0_op2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_owner   <= 1'b0;
            m_data    <= 32'd0;
            m_refused <= 0;
        end else begin
            if (grant_now() >= 0 && room_now()) begin
                m_valid <= 1'b1;
                m_owner <= (grant_now() == 1);
                m_data  <= winner_result();
            end else if (m_valid && room_now()) begin
                m_valid <= 1'b0;
            end
            if (!bus.p1_req_valid || (grant_now() == 1 && room_now()))
                m_refused <= 0;
            else if (m_refused < STARVE_MAX)
                m_refused <= m_refused + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("p0_rsp_valid", bus.p0_rsp_valid, m_valid && !m_owner);
        checkOutput("p1_rsp_valid", bus.p1_rsp_valid, m_valid && m_owner);
        checkOutput("p0_rsp_data", bus.p0_rsp_data, (m_valid && !m_owner) ? m_data : 32'd0);
        checkOutput("p1_rsp_data", bus.p1_rsp_data, (m_valid && m_owner) ? m_data : 32'd0);
        checkOutput("busy", bus.busy, m_valid);
        if (rst_n) begin
            checkOutput("p0_req_ready", bus.p0_req_ready, grant_now() == 0 && room_now());
            checkOutput("p1_req_ready", bus.p1_req_ready, grant_now() == 1 && room_now());
            checkOutput("alu_op", bus.alu_op, grant_now() == 1 ? bus.p1_alu_op :
                                              grant_now() == 0 ? bus.p0_alu_op : 4'd0);
            checkOutput("alu_op1", bus.alu_op1, grant_now() == 1 ? bus.p1_op1 :
                                                grant_now() == 0 ? bus.p0_op1 : 32'd0);
            checkOutput("alu_op2", bus.alu_op2, grant_now() == 1 ? bus.p1_op2 :
                                                grant_now() == 0 ? bus.p0_op2 : 32'd0);
        end
    end

    task automatic applyStimulus(input bit p0v, input logic [3:0] p0op, input logic [31:0] p0a,
                                 input logic [31:0] p0b, input bit p1v, input logic [3:0] p1op,
                                 input logic [31:0] p1a, input logic [31:0] p1b, input bit fl,
                                 input bit p0rr, input bit p1rr);
        bus.p0_req_valid = p0v;
        bus.p0_alu_op    = p0op;
        bus.p0_op1       = p0a;
        bus.p0_op2       = p0b;
        bus.p1_req_valid = p1v;
        bus.p1_alu_op    = p1op;
        bus.p1_op1       = p1a;
        bus.p1_op2       = p1b;
        bus.flush        = fl;
        bus.p0_rsp_ready = p0rr;
        bus.p1_rsp_ready = p1rr;
    endtask

    task automatic idle(input bit p0rr, input bit p1rr);
        applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, p0rr, p1rr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [9:0] STARVE_PATTERN = 10'b10000_10000;

    initial begin
        logic [9:0] pattern;
        pattern = STARVE_PATTERN;
        rst_n = 1'b0;
        idle(1, 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Basic ADD on port 0
        idle(1, 1);
        #1 checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset p0_rsp_valid", bus.p0_rsp_valid, 0);
        applyStimulus(1, OP_ADD, 5, 7, 0, 4'd0, 0, 0, 0, 1, 1);
        #1 checkOutput("basic p0_req_ready", bus.p0_req_ready, 1);
        step();
        idle(1, 1);
        #1 checkOutput("basic p0_rsp_valid", bus.p0_rsp_valid, 1);
        checkOutput("basic p0_rsp_data", bus.p0_rsp_data, 12);
        checkOutput("basic p1_rsp_valid", bus.p1_rsp_valid, 0);
        step();

        // Eight back-to-back p0 ops, one accept per cycle
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, OP_ADD, 100 + i, i, 0, 4'd0, 0, 0, 0, 1, 1);
            #1 checkOutput("stream ready", bus.p0_req_ready, 1);
            if (i > 0) begin
                checkOutput("stream data", bus.p0_rsp_data, 100 + 2 * (i - 1));
                checkOutput("stream busy", bus.busy, 1);
            end
            step();
        end
        idle(1, 1);
        #1 checkOutput("stream last data", bus.p0_rsp_data, 114);
        step();
        #1 checkOutput("stream drained busy", bus.busy, 0);

        // Back-pressure on port 0, then drain and accept on one edge
        applyStimulus(1, OP_SUB, 50, 8, 0, 4'd0, 0, 0, 0, 0, 1);
        #1 checkOutput("bp first ready", bus.p0_req_ready, 1);
        step();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, OP_OR, 32'hF0, 32'h0F, 0, 4'd0, 0, 0, 0, 0, 1);
            #1 checkOutput("bp held ready", bus.p0_req_ready, 0);
            checkOutput("bp held data", bus.p0_rsp_data, 42);
            step();
        end
        applyStimulus(1, OP_OR, 32'hF0, 32'h0F, 0, 4'd0, 0, 0, 0, 1, 1);
        #1 checkOutput("bp release ready", bus.p0_req_ready, 1);
        step();
        idle(1, 1);
        #1 checkOutput("bp second data", bus.p0_rsp_data, 32'hFF);
        step();

        // Both ports hammering: p0 wins 4, p1 forced on the 5th
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, OP_ADD, 1, 1, 1, OP_OR, 32'h10, 32'h01, 0, 1, 1);
            #1 checkOutput("starve p1_req_ready", bus.p1_req_ready, pattern[i]);
            checkOutput("starve p0_req_ready", bus.p0_req_ready, !pattern[i]);
            if (i == 5) checkOutput("starve p1_rsp_data", bus.p1_rsp_data, 32'h11);
            step();
        end
        idle(1, 1);
        step();

        // Flush kills a held p0 result and lets p1 in on the same edge
        applyStimulus(1, OP_ADD, 20, 22, 0, 4'd0, 0, 0, 0, 0, 1);
        step();
        applyStimulus(1, OP_ADD, 3, 3, 1, OP_NAND, 32'hFF, 32'h0F, 1, 0, 1);
        #1 checkOutput("flush p0_req_ready", bus.p0_req_ready, 0);
        checkOutput("flush p1_req_ready", bus.p1_req_ready, 1);
        checkOutput("flush old p0 data", bus.p0_rsp_data, 42);
        step();
        idle(1, 1);
        #1 checkOutput("flush p0_rsp_valid", bus.p0_rsp_valid, 0);
        checkOutput("flush p1_rsp_valid", bus.p1_rsp_valid, 1);
        checkOutput("flush p1_rsp_data", bus.p1_rsp_data, 32'hF0);
        step();

        // Asynchronous reset with a p1 result parked
        applyStimulus(0, 4'd0, 0, 0, 1, OP_XOR, 32'hA5, 32'h5A, 0, 1, 0);
        #1 checkOutput("rst p1_req_ready", bus.p1_req_ready, 1);
        step();
        idle(1, 0);
        #1 checkOutput("rst parked data", bus.p1_rsp_data, 32'hFF);
        #1 rst_n = 1'b0;
        #1 checkOutput("rst p1_rsp_valid", bus.p1_rsp_valid, 0);
        checkOutput("rst busy", bus.busy, 0);
        checkOutput("rst p1_rsp_data", bus.p1_rsp_data, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        idle(1, 1);
        applyStimulus(1, OP_ADD, 5, 7, 0, 4'd0, 0, 0, 0, 1, 1);
        #1 checkOutput("post-rst ready", bus.p0_req_ready, 1);
        step();
        idle(1, 1);
        #1 checkOutput("post-rst p0_rsp_data", bus.p0_rsp_data, 12);
        checkOutput("post-rst p1_rsp_valid", bus.p1_rsp_valid, 0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_ex_alu_arb.md
Name: core_ex_alu_arb

Overview:
- Arbiter and sequencer for the single shared 32-bit ALU in the EX stage.
- Two requesters share it:
  - port 0: main pipeline EX issue, normal priority winner.
  - port 1: CSR/system helper unit, which uses it for csrrs/csrrc OR and NOT_AND read-modify-write.
- Selects one request per cycle, drives the combinational ALU, and captures the result into a single-entry response buffer returned to the owning port.
- A starvation counter guarantees port 1 progress.

Parameters:
DATA_WIDTH, 32, operand/result width
STARVE_MAX, 4, consecutive cycles port 1 may be refused before it is forced to win (1..7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  pipeline flush; cancels port-0 traffic only
p0_req_valid  in  1  port 0 request valid
p0_req_ready  out  1  port 0 request accepted this cycle when high with valid
p0_alu_op  in  4  ALU opcode (ALU_OP_* encoding, passed through)
p0_op1  in  DATA_WIDTH  operand 1
p0_op2  in  DATA_WIDTH  operand 2
p0_rsp_valid  out  1  result for port 0 available
p0_rsp_ready  in  1  port 0 consumes result
p0_rsp_data  out  DATA_WIDTH  result
p1_req_valid, p1_req_ready, p1_alu_op, p1_op1, p1_op2, p1_rsp_valid, p1_rsp_ready, p1_rsp_data: same as port 0, for port 1
alu_op  out  4  opcode to shared ALU
alu_op1  out  DATA_WIDTH  operand 1 to ALU
alu_op2  out  DATA_WIDTH  operand 2 to ALU
alu_res  in  DATA_WIDTH  combinational ALU result of alu_op/alu_op1/alu_op2
busy  out  1  response buffer occupied

Behaviour:
- Reset (rst_n low, async):
  - buf_valid=0, buf_owner=0, buf_data=0, starve_cnt=0.
  - All rsp_valid=0, all rsp_data=0, busy=0.
  - req_ready may be combinationally high, but no acceptance occurs while rst_n is low.
- State: single-entry buffer with two states.
  - EMPTY (buf_valid=0).
  - FULL (buf_valid=1, buf_owner in {0,1}).
- drain = buf_valid & rsp_ready[buf_owner].
- space = !buf_valid | drain.
- Grant, combinational:
  - gnt1 = p1_req_valid & (!p0_eff | starve_cnt==STARVE_MAX).
  - gnt0 = p0_eff & !gnt1.
  - p0_eff = p0_req_valid & !flush.
- Ready signals:
  - p0_req_ready = gnt0 & space.
  - p1_req_ready = gnt1 & space.
  - Both depend on rsp_ready; this is a permitted comb path.
- ALU drive:
  - Granted port's op/op1/op2 go to the ALU irrespective of space.
  - With no grant, the ALU is driven with alu_op=0 and operands 0.
- Accept edge: on a rising edge with a req_ready high, buf_data<=alu_res, buf_owner<=granted port, buf_valid<=1.
- Latency: rsp_valid rises exactly 1 cycle after acceptance.
- Throughput: 1 op/cycle when the owner drains every cycle (drain and accept in the same edge → stays FULL).
- Drain without accept: FULL→EMPTY.
- Response outputs:
  - rsp_valid[x] = buf_valid & buf_owner==x.
  - rsp_data[x] = buf_data when owned, else 0.
  - Held stable while not drained.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each edge where p1_req_valid=1 and p1 is not accepted.
  - Clears on p1 acceptance, or on any edge with p1_req_valid=0.
  - Back-pressure refusals also count.
- Flush (synchronous):
  - If buf_owner=0 and buf_valid, the buffer is invalidated at that edge.
  - That invalidation makes space, so an accept on p1 in the same cycle is allowed.
  - p0 is never accepted in a flush cycle.
  - A p1-owned buffer is unaffected.
- busy = buf_valid.
- Requester stability: requesters hold op/operands stable while valid and not ready; the arbiter does not check this.

Test Plan:
- Basic op: p0 only, p0_alu_op=ADD, op1=5, op2=7, p0_rsp_ready=1 → p0_req_ready=1 in the same cycle; next cycle p0_rsp_valid=1, p0_rsp_data=12 (ALU model); p1_rsp_valid=0.
- Back-to-back streaming: p0 issues 8 consecutive requests with rsp_ready=1 → 8 accepts in 8 cycles, results in order, busy high from cycle 1 through cycle 8.
- Back-pressure: p0_rsp_ready=0 after the first accept → buffer holds, p0_rsp_data stable, p0_req_ready=0 until rsp_ready=1; drain and next accept occur on the same edge.
- Starvation: p0 and p1 both valid continuously, STARVE_MAX=4 → p0 wins 4 cycles, p1 wins the 5th, starve_cnt returns to 0, pattern repeats (4:1).
- Flush: buffer holds a p0 result, flush=1 while p1 is valid → p0_rsp_valid drops next cycle, p1 accepted at the flush edge, p1_rsp_valid=1 next cycle; p0 is not accepted during flush even if p0_req_valid=1.
- Async reset mid-operation: rst_n dropped between clock edges with a p1 result buffered → p1_rsp_valid, busy and rsp_data go to 0 immediately; after release, the first request behaves as in the basic-op scenario.
